// File: rtl/ocp3_nic_pwr_scheduler_if.sv
// rtl/ocp3_nic_pwr_scheduler_if.sv - slot request/done and grant/status bundle for the NIC power scheduler
interface ocp3_nic_pwr_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic [NUM_SLOTS-1:0] iReq;
    logic [NUM_SLOTS-1:0] iDone;
    logic [NUM_SLOTS-1:0] oGrant;
    logic                 oBusy;
    logic [NUM_SLOTS-1:0] oFault;
    logic [1:0]           oDBG_SCHED_FSM;

    modport master (
        output iReq,
        output iDone,
        input  oGrant,
        input  oBusy,
        input  oFault,
        input  oDBG_SCHED_FSM
    );

    modport slave (
        input  iReq,
        input  iDone,
        output oGrant,
        output oBusy,
        output oFault,
        output oDBG_SCHED_FSM
    );
endinterface

// File: rtl/ocp3_nic_pwr_scheduler.sv
// rtl/ocp3_nic_pwr_scheduler.sv - one-at-a-time round-robin main-power ramp grant with settle gap; grant timeout via OCP3_NIC_SCHED_TIMEOUT_EN
module ocp3_nic_pwr_scheduler #(
    parameter int          NUM_SLOTS  = 4,
    parameter logic [15:0] GAP_MS     = 16'd5,
    parameter logic [15:0] TIMEOUT_MS = 16'd1100
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iTick_1ms,
    ocp3_nic_pwr_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] S0_IDLE   = 2'b00;
    localparam logic [1:0] S1_GRANT  = 2'b01;
    localparam logic [1:0] S2_SETTLE = 2'b10;

    logic [1:0]           rState;
    logic [PTR_W-1:0]     rPtr;
    logic [PTR_W-1:0]     rGrantIdx;
    logic [15:0]          rTickCnt;
    logic [NUM_SLOTS-1:0] rGrant;

    logic [NUM_SLOTS-1:0] wFault;
    logic [NUM_SLOTS-1:0] wEligible;
    logic                 wFound;
    logic [PTR_W-1:0]     wPick;
    logic [PTR_W-1:0]     wNextPtr;
    logic                 wDone;
    logic                 wAbort;
    logic                 wTimeout;
    logic [15:0]          wTickInc;

    assign wEligible = bus.iReq & ~wFault;
    assign wDone     = bus.iDone[rGrantIdx];
    assign wAbort    = ~bus.iReq[rGrantIdx];
    assign wTickInc  = (iTick_1ms && (rTickCnt != 16'hFFFF)) ? rTickCnt + 16'd1 : rTickCnt;
    assign wNextPtr  = (rGrantIdx == PTR_W'(NUM_SLOTS - 1)) ? '0 : rGrantIdx + PTR_W'(1);

    // First eligible slot at or after rPtr, wrapping once around the ring.
    always_comb begin
        int j;
        logic [PTR_W-1:0] idx;
        j      = 0;
        idx    = '0;
        wFound = 1'b0;
        wPick  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            j = int'(rPtr) + k;
            if (j >= NUM_SLOTS) begin
                j = j - NUM_SLOTS;
            end
            idx = PTR_W'(j);
            if (!wFound && wEligible[idx]) begin
                wFound = 1'b1;
                wPick  = idx;
            end
        end
    end

`ifdef OCP3_NIC_SCHED_TIMEOUT_EN
    logic [NUM_SLOTS-1:0] rFault;
    logic [NUM_SLOTS-1:0] wFaultSet;

    assign wTimeout = (rTickCnt == TIMEOUT_MS);

    // Done and abort both take precedence over the timeout, so only a live stalled ramp faults.
    always_comb begin
        wFaultSet = '0;
        if ((rState == S1_GRANT) && wTimeout && !wDone && !wAbort) begin
            wFaultSet[rGrantIdx] = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rFault <= '0;
        end else begin
            rFault <= bus.iReq & (rFault | wFaultSet);
        end
    end

    assign wFault = rFault;
`else
    // TIMEOUT_MS has no effect in this build.
    assign wTimeout = 1'b0 & (rTickCnt == TIMEOUT_MS);
    assign wFault   = '0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState    <= S0_IDLE;
            rPtr      <= '0;
            rGrantIdx <= '0;
            rTickCnt  <= '0;
            rGrant    <= '0;
        end else begin
            case (rState)
                S0_IDLE: begin
                    if (wFound) begin
                        rGrant    <= NUM_SLOTS'(1) << wPick;
                        rGrantIdx <= wPick;
                        rTickCnt  <= '0;
                        rState    <= S1_GRANT;
                    end
                end
                S1_GRANT: begin
                    if (wDone || wAbort || wTimeout) begin
                        rGrant   <= '0;
                        rTickCnt <= '0;
                        rPtr     <= wNextPtr;
                        rState   <= S2_SETTLE;
                    end else begin
                        rTickCnt <= wTickInc;
                    end
                end
                S2_SETTLE: begin
                    if (rTickCnt == GAP_MS) begin
                        rTickCnt <= '0;
                        rState   <= S0_IDLE;
                    end else begin
                        rTickCnt <= wTickInc;
                    end
                end
                default: begin
                    rGrant   <= '0;
                    rTickCnt <= '0;
                    rState   <= S0_IDLE;
                end
            endcase
        end
    end

    assign bus.oGrant         = rGrant;
    assign bus.oBusy          = (rState == S1_GRANT) || (rState == S2_SETTLE);
    assign bus.oFault         = wFault;
    assign bus.oDBG_SCHED_FSM = rState;
endmodule

// File: tb/tb_ocp3_nic_pwr_scheduler.sv
// tb/tb_ocp3_nic_pwr_scheduler.sv - self-checking bench for ocp3_nic_pwr_scheduler (both OCP3_NIC_SCHED_TIMEOUT_EN builds)
module tb_ocp3_nic_pwr_scheduler;
    localparam int NS   = 4;
    localparam int GAP  = 5;
    localparam int TOUT = 20;
`ifdef OCP3_NIC_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic       tick;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] fsm;
        logic [3:0] fault;
    } vec_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;
    always #5 clk = ~clk;

    ocp3_nic_pwr_scheduler_if #(.NUM_SLOTS(NS)) busA ();
    ocp3_nic_pwr_scheduler_if #(.NUM_SLOTS(NS)) busB ();

    ocp3_nic_pwr_scheduler #(.NUM_SLOTS(NS), .GAP_MS(16'(GAP)), .TIMEOUT_MS(16'(TOUT))) dutA (
        .iClk(clk), .iRst(rst), .iTick_1ms(tick), .bus(busA.slave)
    );
    ocp3_nic_pwr_scheduler #(.NUM_SLOTS(NS), .GAP_MS(16'd0), .TIMEOUT_MS(16'(TOUT))) dutB (
        .iClk(clk), .iRst(rst), .iTick_1ms(tick), .bus(busB.slave)
    );

    int nChk  = 0;
    int nFail = 0;
    int cyc   = 0;

    vec_t vecs[22];

    // Reference: owner slot (-1 none), ticks held, settle flag/count, search start, fault flags
    int         mOwner;
    int         mHeld;
    int         mSettle;
    int         mSetCnt;
    int         mPtr;
    logic [3:0] mFault;

    function automatic vec_t mk(logic [3:0] r, logic [3:0] d, logic t, logic [3:0] g,
                                logic b, logic [1:0] f, logic [3:0] flt);
        vec_t v;
        v.req = r; v.done = d; v.tick = t; v.grant = g; v.busy = b; v.fsm = f; v.fault = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
        cyc++;
    endtask

    task automatic doReset();
        rst = 1'b1;
        busA.iReq = '0; busA.iDone = '0;
        busB.iReq = '0; busB.iDone = '0;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
    endtask

    task automatic modelEdge(input logic [3:0] r, input logic [3:0] d, input logic t);
        logic [3:0] setF;
        int s;
        setF = '0;
        if (mOwner >= 0) begin
            if (d[mOwner] || !r[mOwner] || (TO_EN && mHeld == TOUT)) begin
                if (TO_EN && !d[mOwner] && r[mOwner]) setF[mOwner] = 1'b1;
                mPtr    = (mOwner + 1) % NS;
                mOwner  = -1;
                mSettle = 1;
                mSetCnt = 0;
            end else if (t && mHeld < 65535) begin
                mHeld++;
            end
        end else if (mSettle != 0) begin
            if (mSetCnt == GAP) mSettle = 0;
            else if (t && mSetCnt < 65535) mSetCnt++;
        end else begin
            for (int k = 0; k < NS; k++) begin
                s = (mPtr + k) % NS;
                if (mOwner < 0 && r[s] && !mFault[s]) begin
                    mOwner = s;
                    mHeld  = 0;
                end
            end
        end
        mFault = (mFault | setF) & r;
    endtask

    function automatic logic [10:0] modelOut();
        logic [3:0] g;
        logic [1:0] f;
        g = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        f = (mOwner >= 0) ? 2'b01 : ((mSettle != 0) ? 2'b10 : 2'b00);
        return {g, (mOwner >= 0) || (mSettle != 0), mFault, f};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] d;
        logic       t;
        int         gapTicks;
        bit         got;
        bit         multiHot;

        // Single request, abort, wrap-around search and done+req-low, one cycle per row
        vecs[0]  = mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'b01, 4'b0000);
        vecs[1]  = mk(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'b01, 4'b0000);
        vecs[2]  = mk(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[3]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[4]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[5]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[6]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[7]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[8]  = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 4'b0000);
        vecs[9]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'b01, 4'b0000);
        vecs[10] = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'b01, 4'b0000);
        vecs[11] = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'b01, 4'b0000);
        vecs[12] = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'b01, 4'b0000);
        vecs[13] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[14] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[15] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[16] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[17] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[18] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10, 4'b0000);
        vecs[19] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 4'b0000);
        vecs[20] = mk(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'b01, 4'b0000);
        vecs[21] = mk(4'b0010, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'b10, 4'b0000);

        doReset();
        chk("reset_a", {busA.oGrant, busA.oBusy, busA.oFault, busA.oDBG_SCHED_FSM}, 32'h0);
        chk("reset_b", {busB.oGrant, busB.oBusy, busB.oFault, busB.oDBG_SCHED_FSM}, 32'h0);

        for (int i = 0; i < 22; i++) begin
            busA.iReq  = vecs[i].req;
            busA.iDone = vecs[i].done;
            step(vecs[i].tick);
            chk($sformatf("vec%0d", i),
                {busA.oGrant, busA.oBusy, busA.oDBG_SCHED_FSM, busA.oFault},
                {vecs[i].grant, vecs[i].busy, vecs[i].fsm, vecs[i].fault});
        end

        // Round-robin with all slots requesting
        doReset();
        busA.iReq = 4'hF;
        multiHot = 1'b0;
        for (int g = 0; g < 5; g++) begin
            gapTicks = 0;
            got      = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                t = ((cyc % 4) == 0);
                if (busA.oGrant == 4'b0000 && t) gapTicks++;
                step(t);
                if (!$onehot0(busA.oGrant)) multiHot = 1'b1;
                if (busA.oGrant != 4'b0000) got = 1'b1;
            end
            chk($sformatf("rr_order%0d", g), busA.oGrant, 4'b0001 << (g % 4));
            if (g > 0) chk($sformatf("rr_gap%0d", g), (gapTicks >= GAP), 1);
            busA.iDone = busA.oGrant;
            step(1'b0);
            chk($sformatf("rr_release%0d", g), busA.oGrant, 4'b0000);
            busA.iDone = 4'b0000;
        end
        chk("rr_onehot", multiHot, 1'b0);

        // Zero-gap instance: regrant two cycles after release
        doReset();
        busB.iReq = 4'b0001;
        step(1'b0);
        chk("gap0_grant", busB.oGrant, 4'b0001);
        busB.iDone = 4'b0001;
        step(1'b0);
        chk("gap0_release", busB.oGrant, 4'b0000);
        busB.iDone = 4'b0000;
        step(1'b0);
        chk("gap0_idle", {busB.oGrant, busB.oDBG_SCHED_FSM}, {4'b0000, 2'b00});
        step(1'b0);
        chk("gap0_regrant", busB.oGrant, 4'b0001);
        busB.iReq = 4'b0000;

        // Asynchronous reset mid-grant also rewinds the search pointer
        doReset();
        busA.iReq = 4'b0100;
        step(1'b0);
        busA.iDone = 4'b0100;
        step(1'b0);
        busA.iDone = 4'b0000;
        busA.iReq  = 4'b0000;
        repeat (GAP) step(1'b1);
        step(1'b0);
        busA.iReq = 4'b1000;
        step(1'b0);
        chk("rst_pre_grant", busA.oGrant, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_grant", {busA.oGrant, busA.oBusy, busA.oDBG_SCHED_FSM}, 32'h0);
        step(1'b0);
        rst = 1'b0;
        busA.iReq = 4'hF;
        step(1'b0);
        chk("rst_ptr", busA.oGrant, 4'b0001);

`ifdef OCP3_NIC_SCHED_TIMEOUT_EN
        doReset();
        busA.iReq = 4'b0001;
        step(1'b0);
        repeat (TOUT) step(1'b1);
        chk("to_hold", busA.oGrant, 4'b0001);
        step(1'b0);
        chk("to_expire", {busA.oGrant, busA.oFault}, {4'b0000, 4'b0001});
        busA.iReq = 4'b0011;
        repeat (GAP) step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("to_skip", busA.oGrant, 4'b0010);
        busA.iDone = 4'b0010;
        step(1'b0);
        busA.iDone = 4'b0000;
        busA.iReq  = 4'b0001;
        repeat (GAP) step(1'b1);
        repeat (4) step(1'b0);
        chk("to_excluded", {busA.oGrant, busA.oFault}, {4'b0000, 4'b0001});
        busA.iReq = 4'b0000;
        step(1'b0);
        chk("to_fault_clear", busA.oFault, 4'b0000);
        busA.iReq = 4'b0001;
        step(1'b0);
        chk("to_regrant", busA.oGrant, 4'b0001);

        doReset();
        busA.iReq = 4'b0001;
        step(1'b0);
        repeat (TOUT) step(1'b1);
        busA.iDone = 4'b0001;
        step(1'b1);
        chk("to_done_wins", {busA.oGrant, busA.oFault, busA.oDBG_SCHED_FSM}, {4'b0000, 4'b0000, 2'b10});
        busA.iDone = 4'b0000;
`else
        doReset();
        busA.iReq = 4'b0001;
        step(1'b0);
        repeat (TOUT + 5) step(1'b1);
        chk("no_timeout", {busA.oGrant, busA.oFault}, {4'b0001, 4'b0000});
`endif

        // Randomised requesters against the reference
        doReset();
        mOwner = -1; mHeld = 0; mSettle = 0; mSetCnt = 0; mPtr = 0; mFault = '0;
        for (int c = 0; c < 4000; c++) begin
            r = busA.iReq;
            d = busA.iDone;
            for (int i = 0; i < NS; i++) begin
                if (!r[i]) begin
                    d[i] = 1'b0;
                    if ($urandom_range(7) == 0) r[i] = 1'b1;
                end else if (busA.oGrant[i]) begin
                    if ($urandom_range(29) == 0) d[i] = 1'b1;
                    else if ($urandom_range(39) == 0) r[i] = 1'b0;
                end else if (d[i]) begin
                    r[i] = 1'b0;
                    d[i] = 1'b0;
                end else if ($urandom_range(59) == 0) begin
                    r[i] = 1'b0;
                end
            end
            busA.iReq  = r;
            busA.iDone = d;
            t = ($urandom_range(2) == 0);
            modelEdge(r, d, t);
            step(t);
            chk("rand", {busA.oGrant, busA.oBusy, busA.oFault, busA.oDBG_SCHED_FSM}, modelOut());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
